structure2_decision: RTL and testbench
======================================

// Module: structure2_decision
// PURPOSE
//  Consumes the packed logit pairs emitted by the structure2 FC2 stage (one 16-bit word per species,
//  upper byte = class-0 logit, lower byte = class-1 logit, both signed 8-bit).
//  Computes a per-species class decision and confidence margin.
//  Buffers the per-species results in a small FIFO with a valid/ready output.
//  After SPECIES words, produces a frame-level majority vote.
// PARAMETERS
//  SPECIES     42  logit pairs per frame (1..64)
//  FIFO_DEPTH  8   result FIFO entries (power of 2)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  clear        in   1   synchronous frame restart (flush + zero)
//  in_vld       in   1   input word valid, single-cycle pulse; no backpressure upstream
//  in_data      in   16  [15:8] logit0, [7:0] logit1, signed two's complement
//  out_vld      out  1   FIFO head valid (= FIFO not empty)
//  out_rdy      in   1   consumer accepts head when out_vld & out_rdy
//  out_data     out  16  {idx[5:0], cls, 1'b0, margin[7:0]}
//  pos_count    out  7   number of cls=1 decisions in current frame
//  frame_done   out  1   one-cycle pulse when frame summary valid
//  frame_class  out  1   majority result, held until clear/reset
//  overflow     out  1   sticky: a result or input was dropped
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, idx=0, state IDLE.
//  Decision stage (registered, cycle N = in_vld cycle):
//   - diff = $signed(logit1) - $signed(logit0), 9-bit signed.
//   - cls = diff > 0; tie gives cls=0.
//   - margin = |diff| in 8 bits unsigned (max 255).
//   - idx = species counter (0..SPECIES-1).
//   - pos_count updates at the end of cycle N.
//  FIFO: entry written at the end of cycle N+1; out_vld high from cycle N+2 if FIFO was empty.
//   - Order is strictly FIFO.
//   - out_data is stable while out_vld & !out_rdy.
//  Full FIFO:
//   - Push with a pop in the same cycle is accepted.
//   - Push without a pop drops the entry and sets overflow.
//   - pos_count and idx still advance on a dropped entry.
//  Pop on empty is ignored.
//  FSM:
//   - IDLE: first in_vld processed as idx 0 -> COLLECT.
//   - COLLECT: each in_vld increments idx. The word with idx = SPECIES-1 -> SUMMARY.
//   - SUMMARY: 1 cycle, entered the cycle after that word's decision is registered.
//     Sets frame_class = (pos_count > SPECIES/2), strict; 21 of 42 gives 0.
//     Pulses frame_done -> DONE.
//   - DONE: holds frame_class and pos_count. Any in_vld is ignored and sets overflow. FIFO keeps draining.
//   - clear (any state) -> IDLE.
//   - An in_vld arriving in SUMMARY is ignored and sets overflow.
//  clear:
//   - Highest synchronous priority; same-cycle in_vld is discarded.
//   - Empties the FIFO, so out_vld is 0 the next cycle.
//   - Zeros idx, pos_count, frame_class and overflow.
//   - frame_done is not asserted.
//  Async reset mid-frame: all state returns to reset values immediately.
// TESTING
//  T1 42x in_data=16'h1020, out_rdy=1 -> 42 entries idx 0..41, cls=1, margin=16; pos_count=42, frame_class=1, one frame_done.
//  T2 16'h0505 -> cls=0, margin=0; 16'h807F -> cls=1, margin=255; 16'h7F80 -> cls=0, margin=255.
//  T3 out_rdy=0, 10 pulses -> out_vld=1, overflow=1 after 9th, pos_count=10; out_rdy=1 drains idx 0..7 in order, then out_vld=0.
//  T4 frame with exactly 21 positives -> frame_class=0; 22 positives -> frame_class=1; pulse after 42nd word only.
//  T5 clear after 20 words -> next cycle out_vld=0, pos_count=0, overflow=0; next word gets idx=0; extra word in DONE sets overflow.
//  T6 rst_n low mid-COLLECT with FIFO non-empty -> all outputs 0 asynchronously; clean 42-word frame after release matches T1.

Source files
------------

// File: rtl/structure2_decision_if.sv
// Purpose : handshake bundle between the FC2 logit stream, the decision block and its result consumer.
// Latency : n/a (wires only).
// Backpressure: input side has none (in_vld is a pulse); output side is valid/ready.
//
// Signals:
//   in_vld   - logit-pair word valid, single-cycle pulse
//   in_data  - [15:8] class-0 logit, [7:0] class-1 logit, signed 8-bit each
//   out_vld  - result FIFO head valid
//   out_rdy  - consumer takes the head when out_vld & out_rdy
//   out_data - {idx[5:0], cls, 1'b0, margin[7:0]}
// slave  = decision block side, master = producer/consumer side.
interface structure2_decision_if;
    logic        in_vld;
    logic [15:0] in_data;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] out_data;

    modport slave (
        input  in_vld,
        input  in_data,
        output out_vld,
        input  out_rdy,
        output out_data
    );

    modport master (
        output in_vld,
        output in_data,
        input  out_vld,
        output out_rdy,
        input  out_data
    );
endinterface

// File: rtl/structure2_decision.sv
// Purpose : per-species class decision + margin on FC2 logit pairs, buffered results, frame majority vote.
// Latency : decision registered 1 cycle after in_vld, FIFO write 1 cycle later, out_vld 2 cycles after in_vld.
// Backpressure: none upstream; a full FIFO with no pop drops the result and sets the sticky overflow flag.
//
// Ports (top):
//   clk, rst_n       - clock, asynchronous active-low reset
//   clear            - synchronous frame restart: flushes FIFO, zeros idx/pos_count/frame_class/overflow
//   bus (slave)      - in_vld/in_data input stream, out_vld/out_rdy/out_data result stream
//   pos_count[6:0]   - number of cls=1 decisions in the current frame
//   frame_done       - one-cycle pulse when frame_class becomes valid
//   frame_class      - majority result, held until clear/reset
//   overflow         - sticky: an input or a result was dropped

// Purpose : small generic FIFO with synchronous flush.
// Latency : write visible at the read side the cycle after push.
// Backpressure: push_rdy low when full unless a pop happens in the same cycle.
module structure2_decision_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pop_vld  = (count != '0);
    assign do_pop   = pop_vld & pop_rdy;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_rdy = (count != CW'(DEPTH)) | do_pop;
    assign do_push  = push_vld & push_rdy;
    // Gate the head so the read side shows zero whenever nothing is queued.
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pop_dat is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

module structure2_decision #(
    parameter int SPECIES    = 42,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    structure2_decision_if.slave  bus,
    output logic [6:0]            pos_count,
    output logic                  frame_done,
    output logic                  frame_class,
    output logic                  overflow
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUMMARY = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(SPECIES - 1);
    localparam logic [6:0] HALF     = 7'(SPECIES / 2);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  idx;
    logic        accept;
    logic        reject;
    logic        last_word;
    logic [8:0]  diff;
    logic [7:0]  margin;
    logic        cls;
    logic        dec_vld;
    logic [15:0] dec_dat;
    logic        fifo_push_rdy;

    // Words are only taken while the frame is still collecting; anything
    // arriving in SUMMARY/DONE is discarded and flagged.
    assign accept    = bus.in_vld & ~clear & ((state == IDLE) | (state == COLLECT));
    assign reject    = bus.in_vld & ~clear & ((state == SUMMARY) | (state == DONE));
    assign last_word = (idx == LAST_IDX);

    // 9-bit two's-complement logit1 - logit0; range -255..+255, so |diff|
    // always fits the 8-bit margin.
    assign diff   = {bus.in_data[7], bus.in_data[7:0]} - {bus.in_data[15], bus.in_data[15:8]};
    assign cls    = ~diff[8] & (diff != 9'd0);
    assign margin = diff[8] ? 8'(9'd0 - diff) : diff[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (bus.in_vld) begin
                        state_nxt = last_word ? SUMMARY : COLLECT;
                    end
                end
                SUMMARY: state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            pos_count   <= '0;
            dec_vld     <= 1'b0;
            dec_dat     <= '0;
            frame_done  <= 1'b0;
            frame_class <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            // Also kills a decision still in flight so nothing lands after the flush.
            idx         <= '0;
            pos_count   <= '0;
            dec_vld     <= 1'b0;
            dec_dat     <= '0;
            frame_done  <= 1'b0;
            frame_class <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            dec_vld    <= accept;
            frame_done <= (state == SUMMARY);
            if (accept) begin
                dec_dat   <= {idx, cls, 1'b0, margin};
                idx       <= last_word ? 6'd0 : idx + 6'd1;
                // Counts every accepted decision, including ones the FIFO later drops.
                pos_count <= pos_count + {6'd0, cls};
            end
            if (state == SUMMARY) begin
                frame_class <= (pos_count > HALF);
            end
            if (reject || (dec_vld && !fifo_push_rdy)) begin
                overflow <= 1'b1;
            end
        end
    end

    structure2_decision_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (clear),
        .push_vld (dec_vld),
        .push_dat (dec_dat),
        .push_rdy (fifo_push_rdy),
        .pop_vld  (bus.out_vld),
        .pop_rdy  (bus.out_rdy),
        .pop_dat  (bus.out_data)
    );
endmodule

// File: tb/tb_structure2_decision.sv
// Purpose : self-checking bench for structure2_decision against a behavioural frame model.
// Latency : n/a.
// Backpressure: out_rdy driven per scenario (held, stalled or randomized).
`timescale 1ns/1ps
module tb_structure2_decision;
    localparam int SPECIES = 42;
    localparam int DEPTH   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] pos_count;
    logic       frame_done;
    logic       frame_class;
    logic       overflow;

    structure2_decision_if bus();

    structure2_decision #(
        .SPECIES    (SPECIES),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .bus         (bus),
        .pos_count   (pos_count),
        .frame_done  (frame_done),
        .frame_class (frame_class),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    int          fd_count = 0;
    int          obs_base = 0;
    int          fd_base  = 0;
    int          m_cnt    = 0;
    int          m_pos    = 0;

    // Record every accepted result and every frame_done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.out_vld && bus.out_rdy) obs_q.push_back(bus.out_data);
        if (rst_n && frame_done) fd_count++;
    end

    function automatic int to_s8(input logic [7:0] b);
        return (b >= 8'd128) ? int'(b) - 256 : int'(b);
    endfunction

    function automatic bit model_cls(input logic [15:0] d);
        return (to_s8(d[7:0]) - to_s8(d[15:8])) > 0;
    endfunction

    function automatic logic [15:0] model_word(input int idx, input logic [15:0] d);
        int diff;
        int mag;
        diff = to_s8(d[7:0]) - to_s8(d[15:8]);
        mag  = (diff < 0) ? -diff : diff;
        return 16'(idx * 1024 + (diff > 0 ? 512 : 0) + mag);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_pos = 0;
        exp_q.delete();
        obs_base = obs_q.size();
        fd_base  = fd_count;
    endtask

    task automatic do_clear();
        bus.in_vld = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
    endtask

    // One-cycle input pulse; the model accepts words only until the frame is full.
    task automatic send(input logic [15:0] d);
        bus.in_data = d;
        bus.in_vld  = 1'b1;
        if (m_cnt < SPECIES) begin
            exp_q.push_back(model_word(m_cnt, d));
            m_pos += int'(model_cls(d));
            m_cnt++;
        end
        tick();
        bus.in_vld = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({bus.out_vld, bus.out_data, pos_count, frame_done, frame_class, overflow} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got vld=%b dat=%h pos=%0d fd=%b fc=%b ovf=%b want all 0",
                     bus.out_vld, bus.out_data, pos_count, frame_done, frame_class, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic test_all_positive(input bit with_clear);
        if (with_clear) do_clear();
        bus.out_rdy = 1'b1;
        repeat (SPECIES) send(16'h1020);
        for (int c = 0; c < 200 && (obs_q.size() - obs_base) < SPECIES; c++) tick();
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() - obs_base !== SPECIES) begin
            n_fail++; $display("FAIL t1_count got %0d want %0d", obs_q.size() - obs_base, SPECIES);
        end
        for (int i = 0; i < SPECIES && obs_base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[obs_base + i] !== 16'(i * 1024 + 16'h0210)) begin
                n_fail++; $display("FAIL t1_entry[%0d] got %h want %h", i, obs_q[obs_base + i], 16'(i * 1024 + 16'h0210));
            end
        end
        n_checks++;
        if (pos_count !== 7'd42 || frame_class !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL t1_status got pos=%0d fc=%b ovf=%b want 42 1 0", pos_count, frame_class, overflow);
        end
        n_checks++;
        if (fd_count - fd_base !== 1) begin
            n_fail++; $display("FAIL t1_frame_done got %0d pulses want 1", fd_count - fd_base);
        end
    endtask

    task automatic test_extremes();
        logic [15:0] want [3];
        want[0] = 16'h0000; want[1] = 16'h06FF; want[2] = 16'h08FF;
        do_clear();
        bus.out_rdy = 1'b1;
        send(16'h0505); send(16'h807F); send(16'h7F80);
        for (int c = 0; c < 50 && (obs_q.size() - obs_base) < 3; c++) tick();
        repeat (2) tick();
        n_checks++;
        if (obs_q.size() - obs_base !== 3) begin
            n_fail++; $display("FAIL t2_count got %0d want 3", obs_q.size() - obs_base);
        end
        for (int i = 0; i < 3 && obs_base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[obs_base + i] !== want[i]) begin
                n_fail++; $display("FAIL t2_entry[%0d] got %h want %h", i, obs_q[obs_base + i], want[i]);
            end
        end
        n_checks++;
        if (pos_count !== 7'd1 || fd_count != fd_base || overflow !== 1'b0) begin
            n_fail++; $display("FAIL t2_status got pos=%0d fd=%0d ovf=%b want 1 0 0", pos_count, fd_count - fd_base, overflow);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        bus.out_rdy = 1'b0;
        repeat (8) send(16'h1020);
        repeat (3) tick();
        n_checks++;
        if (overflow !== 1'b0 || bus.out_vld !== 1'b1 || bus.out_data !== 16'h0210) begin
            n_fail++; $display("FAIL t3_full got ovf=%b vld=%b dat=%h want 0 1 0210", overflow, bus.out_vld, bus.out_data);
        end
        send(16'h1020); send(16'h1020);
        repeat (3) tick();
        n_checks++;
        if (overflow !== 1'b1 || pos_count !== 7'd10 || bus.out_data !== 16'h0210) begin
            n_fail++; $display("FAIL t3_drop got ovf=%b pos=%0d dat=%h want 1 10 0210", overflow, pos_count, bus.out_data);
        end
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 50 && (obs_q.size() - obs_base) < DEPTH; c++) tick();
        repeat (5) tick();
        n_checks++;
        if (obs_q.size() - obs_base !== DEPTH || bus.out_vld !== 1'b0) begin
            n_fail++; $display("FAIL t3_drain got %0d entries vld=%b want %0d 0", obs_q.size() - obs_base, bus.out_vld, DEPTH);
        end
        for (int i = 0; i < DEPTH && obs_base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[obs_base + i] !== exp_q[i]) begin
                n_fail++; $display("FAIL t3_entry[%0d] got %h want %h", i, obs_q[obs_base + i], exp_q[i]);
            end
        end
    endtask

    // Random words with exactly npos positive decisions in random positions and
    // random consumer stalls; sending is throttled so the FIFO never drops.
    task automatic test_majority(input int npos);
        bit          flags [SPECIES];
        logic [15:0] d;
        do_clear();
        for (int i = 0; i < SPECIES; i++) flags[i] = (i < npos);
        for (int i = SPECIES - 1; i > 0; i--) begin
            int j;
            bit t;
            j = $urandom_range(0, i);
            t = flags[i]; flags[i] = flags[j]; flags[j] = t;
        end
        for (int i = 0; i < SPECIES; i++) begin
            do d = 16'($urandom); while (model_cls(d) != flags[i]);
            for (int c = 0; c < 200 && (m_cnt - (obs_q.size() - obs_base)) >= DEPTH; c++) begin
                bus.out_rdy = 1'($urandom_range(0, 1));
                tick();
            end
            if (i == SPECIES - 1) begin
                n_checks++;
                if (fd_count != fd_base) begin
                    n_fail++; $display("FAIL t4_early_done npos=%0d got %0d pulses want 0", npos, fd_count - fd_base);
                end
            end
            bus.out_rdy = 1'($urandom_range(0, 1));
            send(d);
        end
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 200 && (obs_q.size() - obs_base) < SPECIES; c++) tick();
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() - obs_base !== SPECIES) begin
            n_fail++; $display("FAIL t4_count npos=%0d got %0d want %0d", npos, obs_q.size() - obs_base, SPECIES);
        end
        for (int i = 0; i < SPECIES && obs_base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[obs_base + i] !== exp_q[i]) begin
                n_fail++; $display("FAIL t4_entry[%0d] got %h want %h", i, obs_q[obs_base + i], exp_q[i]);
            end
        end
        n_checks++;
        if (pos_count !== 7'(npos) || frame_class !== (npos > SPECIES / 2) || overflow !== 1'b0) begin
            n_fail++; $display("FAIL t4_vote npos=%0d got pos=%0d fc=%b ovf=%b want %0d %b 0",
                               npos, pos_count, frame_class, overflow, npos, npos > SPECIES / 2);
        end
        n_checks++;
        if (fd_count - fd_base !== 1) begin
            n_fail++; $display("FAIL t4_frame_done npos=%0d got %0d pulses want 1", npos, fd_count - fd_base);
        end
    endtask

    task automatic test_clear();
        do_clear();
        bus.out_rdy = 1'b0;
        repeat (20) send(16'($urandom));
        n_checks++;
        if (overflow !== 1'b1 || bus.out_vld !== 1'b1) begin
            n_fail++; $display("FAIL t5_pre got ovf=%b vld=%b want 1 1", overflow, bus.out_vld);
        end
        // Word presented together with clear must be discarded.
        bus.in_data = 16'h1020; bus.in_vld = 1'b1; clear = 1'b1;
        tick();
        bus.in_vld = 1'b0; clear = 1'b0;
        model_reset();
        n_checks++;
        if (bus.out_vld !== 1'b0 || pos_count !== 7'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL t5_clear got vld=%b pos=%0d ovf=%b want 0 0 0", bus.out_vld, pos_count, overflow);
        end
        tick();
        n_checks++;
        if (bus.out_vld !== 1'b0 || pos_count !== 7'd0) begin
            n_fail++; $display("FAIL t5_inflight got vld=%b pos=%0d want 0 0", bus.out_vld, pos_count);
        end
        bus.out_rdy = 1'b1;
        send(16'h1020);
        repeat (SPECIES - 1) send(16'($urandom));
        for (int c = 0; c < 200 && (obs_q.size() - obs_base) < SPECIES; c++) tick();
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() - obs_base < 1 || obs_q[obs_base] !== 16'h0210) begin
            n_fail++; $display("FAIL t5_first_idx got %h want 0210", (obs_q.size() > obs_base) ? obs_q[obs_base] : 16'hxxxx);
        end
        for (int i = 1; i < SPECIES && obs_base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[obs_base + i] !== exp_q[i]) begin
                n_fail++; $display("FAIL t5_entry[%0d] got %h want %h", i, obs_q[obs_base + i], exp_q[i]);
            end
        end
        n_checks++;
        if (pos_count !== 7'(m_pos) || frame_class !== (m_pos > SPECIES / 2) || fd_count - fd_base !== 1) begin
            n_fail++; $display("FAIL t5_frame got pos=%0d fc=%b fd=%0d want %0d %b 1",
                               pos_count, frame_class, fd_count - fd_base, m_pos, m_pos > SPECIES / 2);
        end
        send(16'h1020);
        repeat (4) tick();
        n_checks++;
        if (overflow !== 1'b1 || pos_count !== 7'(m_pos) || obs_q.size() - obs_base !== SPECIES
            || frame_class !== (m_pos > SPECIES / 2) || fd_count - fd_base !== 1) begin
            n_fail++; $display("FAIL t5_done_extra got ovf=%b pos=%0d n=%0d fc=%b want 1 %0d %0d %b",
                               overflow, pos_count, obs_q.size() - obs_base, frame_class, m_pos, SPECIES, m_pos > SPECIES / 2);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        bus.out_rdy = 1'b0;
        repeat (5) send(16'h1020);
        repeat (2) tick();
        n_checks++;
        if (bus.out_vld !== 1'b1 || pos_count !== 7'd5) begin
            n_fail++; $display("FAIL t6_pre got vld=%b pos=%0d want 1 5", bus.out_vld, pos_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_vld, bus.out_data, pos_count, frame_done, frame_class, overflow} !== 27'd0) begin
            n_fail++; $display("FAIL t6_async got vld=%b dat=%h pos=%0d fd=%b fc=%b ovf=%b want all 0",
                               bus.out_vld, bus.out_data, pos_count, frame_done, frame_class, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        model_reset();
        test_all_positive(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        test_reset();
        test_all_positive(1'b1);
        test_extremes();
        test_overflow();
        test_majority(21);
        test_majority(22);
        n = $urandom_range(0, SPECIES);
        test_majority(n);
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
